// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/return sequencer: serialises mepc/mcause/mstatus updates onto the
// single CSR write port, stalls the pipeline, then redirects the PC.
module csr_trap_ctrl #(
  parameter int unsigned     XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            illegal_i,
  input  logic            mret_i,
  input  logic            ext_irq_i,
  input  logic            timer_irq_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mie_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic            ex_csr_we_i,
  input  logic [XLEN-1:0] ex_csr_waddr_i,
  input  logic [XLEN-1:0] ex_csr_wdata_i,
  output logic            csr_we_o,
  output logic [XLEN-1:0] csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            hold_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_addr_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EXT     = {1'b1, (XLEN-1)'(11)};
  localparam logic [XLEN-1:0] CAUSE_TIMER   = {1'b1, (XLEN-1)'(7)};

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_CAUSE, T_STATUS, T_JUMP, R_STATUS, R_JUMP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] jaddr_q, jaddr_d;

  logic            req_c;
  logic            req_mret_c;
  logic [XLEN-1:0] req_cause_c;
  logic [XLEN-1:0] trap_status_c;
  logic [XLEN-1:0] mret_status_c;
  logic [XLEN-1:0] trap_base_c;
  logic [XLEN-1:0] trap_tgt_c;
  logic            unused_mie;

  assign unused_mie = ^{csr_mie_i[XLEN-1:12], csr_mie_i[10:8], csr_mie_i[6:0]};

  // Request priority: exceptions, then mret, then external, then timer interrupt.
  always_comb begin
    req_c       = 1'b0;
    req_mret_c  = 1'b0;
    req_cause_c = '0;
    if (inst_valid_i && illegal_i) begin
      req_c       = 1'b1;
      req_cause_c = CAUSE_ILLEGAL;
    end else if (inst_valid_i && ebreak_i) begin
      req_c       = 1'b1;
      req_cause_c = CAUSE_EBREAK;
    end else if (inst_valid_i && ecall_i) begin
      req_c       = 1'b1;
      req_cause_c = CAUSE_ECALL;
    end else if (mret_i) begin
      req_c      = 1'b1;
      req_mret_c = 1'b1;
    end else if (inst_valid_i && csr_mstatus_i[3] && csr_mie_i[11] && ext_irq_i) begin
      req_c       = 1'b1;
      req_cause_c = CAUSE_EXT;
    end else if (inst_valid_i && csr_mstatus_i[3] && csr_mie_i[7] && timer_irq_i) begin
      req_c       = 1'b1;
      req_cause_c = CAUSE_TIMER;
    end
  end

  // mstatus images for trap entry and mret, plus the trap vector target.
  always_comb begin
    trap_status_c        = csr_mstatus_i;
    trap_status_c[7]     = csr_mstatus_i[3];
    trap_status_c[3]     = 1'b0;
    trap_status_c[12:11] = 2'b11;
    mret_status_c        = csr_mstatus_i;
    mret_status_c[3]     = csr_mstatus_i[7];
    mret_status_c[7]     = 1'b1;
    mret_status_c[12:11] = 2'b11;
    trap_base_c          = {csr_mtvec_i[XLEN-1:2], 2'b00};
    trap_tgt_c           = trap_base_c;
    if (cause_q[XLEN-1] && (csr_mtvec_i[1:0] == 2'b01)) begin
      trap_tgt_c = trap_base_c + XLEN'({cause_q[XLEN-2:0], 2'b00});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      jaddr_q <= RST_PC;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      jaddr_q <= jaddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    pc_d        = pc_q;
    jaddr_d     = jaddr_q;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    hold_o      = 1'b1;
    jump_o      = 1'b0;
    jump_addr_o = jaddr_q;
    unique case (state_q)
      IDLE: begin
        csr_we_o    = ex_csr_we_i;
        csr_waddr_o = ex_csr_waddr_i;
        csr_wdata_o = ex_csr_wdata_i;
        hold_o      = req_c;
        if (req_c) begin
          cause_d = req_cause_c;
          pc_d    = inst_addr_i;
          state_d = req_mret_c ? R_STATUS : T_MEPC;
        end
      end
      T_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = XLEN'(ADDR_MEPC);
        csr_wdata_o = pc_q;
        state_d     = T_CAUSE;
      end
      T_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = XLEN'(ADDR_MCAUSE);
        csr_wdata_o = cause_q;
        state_d     = T_STATUS;
      end
      T_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = XLEN'(ADDR_MSTATUS);
        csr_wdata_o = trap_status_c;
        state_d     = T_JUMP;
      end
      T_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = trap_tgt_c;
        jaddr_d     = trap_tgt_c;
        state_d     = IDLE;
      end
      R_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = XLEN'(ADDR_MSTATUS);
        csr_wdata_o = mret_status_c;
        state_d     = R_JUMP;
      end
      R_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = csr_mepc_i;
        jaddr_d     = csr_mepc_i;
        state_d     = IDLE;
      end
      default: begin
        hold_o  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Table-driven bench for csr_trap_ctrl; expected outputs go through a scoreboard queue.
module tb_csr_trap_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] E_ILL = 32'd8, E_EBR = 32'd4, E_ECALL = 32'd2, E_MRET = 32'd1;
  localparam logic [31:0] I_EXT = 32'd2, I_TMR = 32'd1;

  logic        clk, rst;
  logic        inst_valid, ecall, ebreak, illegal, mret, ext_irq, timer_irq;
  logic [31:0] inst_addr, mstatus, mie, mtvec, mepc;
  logic        ex_we;
  logic [31:0] ex_waddr, ex_wdata;
  logic        csr_we, hold, jump;
  logic [31:0] csr_waddr, csr_wdata, jump_addr;

  csr_trap_ctrl #(.XLEN(32), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid), .inst_addr_i(inst_addr),
    .ecall_i(ecall), .ebreak_i(ebreak), .illegal_i(illegal), .mret_i(mret),
    .ext_irq_i(ext_irq), .timer_irq_i(timer_irq),
    .csr_mstatus_i(mstatus), .csr_mie_i(mie), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .ex_csr_we_i(ex_we), .ex_csr_waddr_i(ex_waddr), .ex_csr_wdata_i(ex_wdata),
    .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .hold_o(hold), .jump_o(jump), .jump_addr_o(jump_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] valid, exc, irq, pc, ms, mi, mt, me, ex_we, ex_wa, ex_wd;
    logic [31:0] we, wa, wd, hold, jump, ja;
  } vec_t;

  typedef struct {
    logic [31:0] we, wa, wd, hold, jump, ja;
    int          id;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  logic [31:0] ms, mi, mt, me;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %h want %h", nm, id, act, exp);
  endtask

  task automatic add(input logic [31:0] valid, exc, irq, pc, xwe, xwa, xwd,
                     input logic [31:0] we, wa, wd, hd, jp, ja);
    tbl.push_back('{valid, exc, irq, pc, ms, mi, mt, me, xwe, xwa, xwd, we, wa, wd, hd, jp, ja});
  endtask

  task automatic drive(input vec_t v);
    inst_valid = v.valid[0];
    illegal    = v.exc[3];
    ebreak     = v.exc[2];
    ecall      = v.exc[1];
    mret       = v.exc[0];
    ext_irq    = v.irq[1];
    timer_irq  = v.irq[0];
    inst_addr  = v.pc;
    mstatus    = v.ms;
    mie        = v.mi;
    mtvec      = v.mt;
    mepc       = v.me;
    ex_we      = v.ex_we[0];
    ex_waddr   = v.ex_wa;
    ex_wdata   = v.ex_wd;
  endtask

  // Drive one row, queue its expectation, compare at the falling edge, advance a cycle.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    drive(v);
    sb.push_back('{v.we, v.wa, v.wd, v.hold, v.jump, v.ja, id});
    @(negedge clk);
    e = sb.pop_front();
    check("ctl{we,hold,jump}", e.id, 32'({csr_we, hold, jump}),
          32'({e.we[0], e.hold[0], e.jump[0]}));
    if (e.we[0]) begin
      check("waddr", e.id, csr_waddr, e.wa);
      check("wdata", e.id, csr_wdata, e.wd);
    end
    check("jump_addr", e.id, jump_addr, e.ja);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_row(input logic [31:0] we, wa, wd, hd, jp, ja);
    add(0, 0, 0, 0, 0, 0, 0, we, wa, wd, hd, jp, ja);
  endtask

  initial begin
    vec_t z;
    z = '{default: 32'h0};
    drive(z);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", -1, 32'({csr_we, hold, jump}), 32'd0);
    check("reset_jaddr", -1, jump_addr, RST_PC);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ecall at 0x100, direct mtvec 0x200
    ms = 0; mi = 0; mt = 32'h200; me = 0;
    add(1, E_ECALL, 0, 32'h100, 0, 0, 0,  0, 0, 0, 1, 0, RST_PC);
    idle_row(1, 32'h341, 32'h100, 1, 0, RST_PC);
    idle_row(1, 32'h342, 32'd11, 1, 0, RST_PC);
    idle_row(1, 32'h300, 32'h1800, 1, 0, RST_PC);
    idle_row(0, 0, 0, 1, 1, 32'h200);
    idle_row(0, 0, 0, 0, 0, 32'h200);
    // external irq, vectored mtvec; irq held high through the sequence
    ms = 32'h8; mi = 32'h800; mt = 32'h201;
    add(1, 0, I_EXT, 32'h40, 0, 0, 0,  0, 0, 0, 1, 0, 32'h200);
    add(1, 0, I_EXT, 32'h48, 0, 0, 0,  1, 32'h341, 32'h40, 1, 0, 32'h200);
    add(1, 0, I_EXT, 32'h48, 0, 0, 0,  1, 32'h342, 32'h8000000B, 1, 0, 32'h200);
    add(1, 0, I_EXT, 32'h48, 0, 0, 0,  1, 32'h300, 32'h1880, 1, 0, 32'h200);
    add(1, 0, I_EXT, 32'h48, 0, 0, 0,  0, 0, 0, 1, 1, 32'h22C);
    ms = 32'h1880;
    add(1, 0, I_EXT, 32'h48, 0, 0, 0,  0, 0, 0, 0, 0, 32'h22C);
    // mret
    me = 32'h44;
    add(1, E_MRET, 0, 32'h22C, 0, 0, 0,  0, 0, 0, 1, 0, 32'h22C);
    idle_row(1, 32'h300, 32'h1888, 1, 0, 32'h22C);
    idle_row(0, 0, 0, 1, 1, 32'h44);
    idle_row(0, 0, 0, 0, 0, 32'h44);
    // illegal with a same-cycle mscratch write, then blocked pipeline writes
    ms = 32'h1888;
    add(1, E_ILL, 0, 32'h80, 1, 32'h340, 32'hDEADBEEF,  1, 32'h340, 32'hDEADBEEF, 1, 0, 32'h44);
    add(0, 0, 0, 0, 1, 32'h340, 32'h12345678,  1, 32'h341, 32'h80, 1, 0, 32'h44);
    add(0, 0, 0, 0, 1, 32'h340, 32'h12345678,  1, 32'h342, 32'd2, 1, 0, 32'h44);
    add(0, 0, 0, 0, 1, 32'h340, 32'h12345678,  1, 32'h300, 32'h1880, 1, 0, 32'h44);
    add(0, 0, 0, 0, 1, 32'h340, 32'h12345678,  0, 0, 0, 1, 1, 32'h200);
    add(0, 0, 0, 0, 1, 32'h340, 32'h12345678,  1, 32'h340, 32'h12345678, 0, 0, 32'h200);
    // masked timer irq and an ecall without inst_valid: no request
    ms = 32'h1880; mi = 32'h80;
    add(1, 0, I_TMR, 32'h90, 0, 0, 0,  0, 0, 0, 0, 0, 32'h200);
    add(0, E_ECALL, 0, 32'h90, 0, 0, 0,  0, 0, 0, 0, 0, 32'h200);
    // enabled timer irq, vectored mtvec 0x301
    ms = 32'h8; mt = 32'h301;
    add(1, 0, I_TMR, 32'h10, 0, 0, 0,  0, 0, 0, 1, 0, 32'h200);
    add(1, 0, I_TMR, 32'h14, 0, 0, 0,  1, 32'h341, 32'h10, 1, 0, 32'h200);
    add(1, 0, I_TMR, 32'h14, 0, 0, 0,  1, 32'h342, 32'h80000007, 1, 0, 32'h200);
    add(1, 0, I_TMR, 32'h14, 0, 0, 0,  1, 32'h300, 32'h1880, 1, 0, 32'h200);
    add(1, 0, I_TMR, 32'h14, 0, 0, 0,  0, 0, 0, 1, 1, 32'h31C);
    idle_row(0, 0, 0, 0, 0, 32'h31C);
    // ecall together with enabled ext irq: exception wins, base target
    mi = 32'h800; mt = 32'h201;
    add(1, E_ECALL, I_EXT, 32'h20, 0, 0, 0,  0, 0, 0, 1, 0, 32'h31C);
    idle_row(1, 32'h341, 32'h20, 1, 0, 32'h31C);
    idle_row(1, 32'h342, 32'd11, 1, 0, 32'h31C);
    idle_row(1, 32'h300, 32'h1880, 1, 0, 32'h31C);
    idle_row(0, 0, 0, 1, 1, 32'h200);
    // ecall+mret: trap only; then back-to-back ebreak from the IDLE cycle
    ms = 0; mi = 0; mt = 32'h200;
    add(1, E_ECALL | E_MRET, 0, 32'h60, 0, 0, 0,  0, 0, 0, 1, 0, 32'h200);
    idle_row(1, 32'h341, 32'h60, 1, 0, 32'h200);
    idle_row(1, 32'h342, 32'd11, 1, 0, 32'h200);
    idle_row(1, 32'h300, 32'h1800, 1, 0, 32'h200);
    idle_row(0, 0, 0, 1, 1, 32'h200);
    add(1, E_EBR, 0, 32'h64, 0, 0, 0,  0, 0, 0, 1, 0, 32'h200);
    idle_row(1, 32'h341, 32'h64, 1, 0, 32'h200);
    idle_row(1, 32'h342, 32'd3, 1, 0, 32'h200);
    idle_row(1, 32'h300, 32'h1800, 1, 0, 32'h200);
    idle_row(0, 0, 0, 1, 1, 32'h200);
    idle_row(0, 0, 0, 0, 0, 32'h200);
    // lead-in for the reset abort sequence
    mt = 32'h208;
    add(1, E_ILL, 0, 32'h90, 0, 0, 0,  0, 0, 0, 1, 0, 32'h200);
    idle_row(1, 32'h341, 32'h90, 1, 0, 32'h200);

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset asserted mid-cycle while in T_CAUSE aborts at once.
    drive(z);
    mtvec = 32'h208;
    #2;
    check("pre_rst_hold", 900, 32'(hold), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_ctl", 901, 32'({csr_we, hold, jump}), 32'd0);
    check("rst_jaddr", 901, jump_addr, RST_PC);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ctl", 902, 32'({csr_we, hold, jump}), 32'd0);
      check("post_rst_jaddr", 902, jump_addr, RST_PC);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
